// File: rtl/vector_issue_ctrl.sv
// Vector issue controller: accepts APU ops, splits each into lane beats,
// buffers one pending op and returns a one-cycle completion per op.
module vector_issue_ctrl #(
  parameter int unsigned LANES     = 4,
  parameter int unsigned VL_WIDTH  = 8,
  parameter int unsigned OP_WIDTH  = 6,
  parameter int unsigned RES_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 apu_req,
  output logic                 apu_gnt,
  input  logic [OP_WIDTH-1:0]  apu_op,
  input  logic [VL_WIDTH-1:0]  apu_vl,
  output logic                 apu_rvalid,
  output logic [RES_WIDTH-1:0] apu_result,
  output logic                 lane_valid,
  output logic [OP_WIDTH-1:0]  lane_op,
  output logic [VL_WIDTH-1:0]  lane_base_idx,
  output logic [LANES-1:0]     lane_mask,
  input  logic                 lane_stall,
  input  logic                 flush,
  output logic                 busy
);

  // Element index carries one extra bit so base never wraps at max vl.
  localparam int unsigned CW = VL_WIDTH + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [VL_WIDTH-1:0] act_vl_q;
  logic [CW-1:0]       base_q;
  logic                pend_valid_q, pend_valid_d;
  logic [OP_WIDTH-1:0] pend_op_q;
  logic [VL_WIDTH-1:0] pend_vl_q;

  logic                accept, beat_adv, last_beat;
  logic [CW-1:0]       rem;
  logic                load, pend_set, pend_clr;
  logic [OP_WIDTH-1:0] load_op;
  logic [VL_WIDTH-1:0] load_vl;

  // Lanes enabled for a beat with rem elements left: lane i active when i < rem.
  function automatic logic [LANES-1:0] beat_mask(input logic [CW-1:0] left);
    logic [LANES-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      m[i] = (left > CW'(i));
    end
    return m;
  endfunction

  // Handshake and beat-progress decode.
  assign apu_gnt       = !reset && !flush && !pend_valid_q;
  assign accept        = apu_req && apu_gnt;
  assign rem           = {1'b0, act_vl_q} - base_q;
  assign beat_adv      = lane_valid && !lane_stall;
  assign last_beat     = beat_adv && (rem <= CW'(LANES));
  assign lane_base_idx = base_q[VL_WIDTH-1:0];

  // Next-state, active-slot load and pending-slot control.
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    load_op  = apu_op;
    load_vl  = apu_vl;
    pend_set = 1'b0;
    pend_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) load = 1'b1;
      end
      EXEC: begin
        if (accept) pend_set = 1'b1;
        if (last_beat) state_d = DONE;
      end
      DONE: begin
        if (pend_valid_q) begin
          load     = 1'b1;
          load_op  = pend_op_q;
          load_vl  = pend_vl_q;
          pend_clr = 1'b1;
        end else if (accept) begin
          load = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A zero-length op has no beats and completes straight away.
    if (load) state_d = (load_vl == '0) ? DONE : EXEC;
    if (flush) begin
      state_d  = IDLE;
      load     = 1'b0;
      pend_set = 1'b0;
      pend_clr = 1'b1;
    end
    pend_valid_d = pend_set ? 1'b1 : (pend_clr ? 1'b0 : pend_valid_q);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Active/pending slots, beat counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      act_vl_q     <= '0;
      base_q       <= '0;
      pend_valid_q <= 1'b0;
      pend_op_q    <= '0;
      pend_vl_q    <= '0;
      lane_valid   <= 1'b0;
      lane_op      <= '0;
      lane_mask    <= '0;
      apu_rvalid   <= 1'b0;
      apu_result   <= '0;
      busy         <= 1'b0;
    end else begin
      lane_valid   <= (state_d == EXEC);
      apu_rvalid   <= (state_d == DONE);
      busy         <= (state_d != IDLE) || pend_valid_d;
      pend_valid_q <= pend_valid_d;
      if (pend_set) begin
        pend_op_q <= apu_op;
        pend_vl_q <= apu_vl;
      end
      if (load) begin
        act_vl_q  <= load_vl;
        lane_op   <= load_op;
        base_q    <= '0;
        lane_mask <= beat_mask({1'b0, load_vl});
      end else if (beat_adv) begin
        base_q    <= base_q + CW'(LANES);
        lane_mask <= beat_mask(rem - CW'(LANES));
      end
      if (state_d == DONE) begin
        apu_result <= RES_WIDTH'(load ? load_vl : act_vl_q);
      end
    end
  end

endmodule

// File: tb/tb_vector_issue_ctrl.sv
// Scoreboard bench for vector_issue_ctrl: directed timing scenarios plus
// randomized ops with random lane stalls against a transaction-level model.
module tb_vector_issue_ctrl;

  localparam int LANES = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        apu_req = 1'b0;
  logic        apu_gnt;
  logic [5:0]  apu_op = '0;
  logic [7:0]  apu_vl = '0;
  logic        apu_rvalid;
  logic [31:0] apu_result;
  logic        lane_valid;
  logic [5:0]  lane_op;
  logic [7:0]  lane_base_idx;
  logic [3:0]  lane_mask;
  logic        lane_stall = 1'b0;
  logic        flush = 1'b0;
  logic        busy;

  typedef struct {
    logic [5:0] op;
    logic [7:0] base;
    logic [3:0] mask;
  } beat_t;

  beat_t      exp_beats[$];
  logic [7:0] exp_res[$];
  int         checks = 0;
  int         failures = 0;
  bit         rand_done = 1'b0;

  vector_issue_ctrl #(.LANES(4), .VL_WIDTH(8), .OP_WIDTH(6), .RES_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .apu_req(apu_req), .apu_gnt(apu_gnt),
    .apu_op(apu_op), .apu_vl(apu_vl), .apu_rvalid(apu_rvalid),
    .apu_result(apu_result), .lane_valid(lane_valid), .lane_op(lane_op),
    .lane_base_idx(lane_base_idx), .lane_mask(lane_mask),
    .lane_stall(lane_stall), .flush(flush), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Expected transactions of one op: ceil(vl/LANES) beats then a completion.
  task automatic push_expect(input logic [5:0] op, input logic [7:0] vl);
    int v, nb, left;
    beat_t b;
    v  = int'(vl);
    nb = (v + LANES - 1) / LANES;
    for (int k = 0; k < nb; k++) begin
      left   = v - k * LANES;
      b.op   = op;
      b.base = 8'(k * LANES);
      b.mask = (left >= LANES) ? 4'hF : 4'((1 << left) - 1);
      exp_beats.push_back(b);
    end
    exp_res.push_back(vl);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Request until granted (bounded); returns one cycle after the accept edge.
  task automatic issue(input logic [5:0] op, input logic [7:0] vl);
    int waited;
    bit ok;
    waited  = 0;
    ok      = 1'b0;
    apu_req = 1'b1;
    apu_op  = op;
    apu_vl  = vl;
    while (!ok && waited < 500) begin
      @(negedge clk);
      if (apu_gnt) ok = 1'b1;
      else waited++;
    end
    if (ok) begin
      push_expect(op, vl);
    end else begin
      checks++;
      failures++;
      $display("FAIL gnt_timeout actual=0 required=1");
      apu_req = 1'b0;
    end
    next_cycle();
    apu_req = 1'b0;
  endtask

  // Monitor: pops the model whenever the DUT presents a beat or a completion.
  always @(negedge clk) begin
    if (!reset) begin
      if (lane_valid && !lane_stall) begin
        if (exp_beats.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL beat_unexpected actual=base %0d required=none", lane_base_idx);
        end else begin
          beat_t e;
          e = exp_beats.pop_front();
          check("beat_op", 32'(lane_op), 32'(e.op));
          check("beat_base", 32'(lane_base_idx), 32'(e.base));
          check("beat_mask", 32'(lane_mask), 32'(e.mask));
        end
      end
      if (apu_rvalid) begin
        if (exp_res.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rvalid_unexpected actual=%0d required=none", apu_result);
        end else begin
          logic [7:0] r;
          r = exp_res.pop_front();
          check("result", apu_result, 32'(r));
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int drain;
    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", 32'(apu_gnt), 0);
    check("rst_lane_valid", 32'(lane_valid), 0);
    check("rst_rvalid", 32'(apu_rvalid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_result", apu_result, 0);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check("idle_gnt", 32'(apu_gnt), 1);
    next_cycle();

    // op=5 vl=10: beats cycles 1-3, rvalid cycle 4, idle cycle 5.
    issue(6'd5, 8'd10);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check("a_valid", 32'(lane_valid), 1);
      check("a_op", 32'(lane_op), 5);
      check("a_base", 32'(lane_base_idx), 32'((c - 1) * 4));
      check("a_mask", 32'(lane_mask), (c == 3) ? 32'h3 : 32'hF);
    end
    @(negedge clk);
    check("a_rvalid", 32'(apu_rvalid), 1);
    check("a_result", apu_result, 10);
    check("a_valid_off", 32'(lane_valid), 0);
    @(negedge clk);
    check("a_busy_off", 32'(busy), 0);
    check("a_rvalid_off", 32'(apu_rvalid), 0);
    next_cycle();

    // vl=0: no beats, rvalid on the cycle after accept.
    issue(6'd17, 8'd0);
    @(negedge clk);
    check("z_valid", 32'(lane_valid), 0);
    check("z_rvalid", 32'(apu_rvalid), 1);
    check("z_result", apu_result, 0);
    next_cycle();

    // vl=8 with stall in cycles 1-2.
    issue(6'd9, 8'd8);
    lane_stall = 1'b1;
    @(negedge clk);
    check("s_base_c1", 32'(lane_base_idx), 0);
    @(negedge clk);
    check("s_base_c2", 32'(lane_base_idx), 0);
    check("s_valid_c2", 32'(lane_valid), 1);
    next_cycle();
    lane_stall = 1'b0;
    @(negedge clk);
    check("s_base_c3", 32'(lane_base_idx), 0);
    @(negedge clk);
    check("s_base_c4", 32'(lane_base_idx), 4);
    @(negedge clk);
    check("s_rvalid_c5", 32'(apu_rvalid), 1);
    check("s_result", apu_result, 8);
    next_cycle();

    // Back-to-back: A vl=4 then B vl=6 into pending.
    issue(6'd1, 8'd4);
    issue(6'd2, 8'd6);
    apu_req = 1'b1;
    apu_op  = 6'd33;
    apu_vl  = 8'd3;
    @(negedge clk);
    check("bb_a_rvalid", 32'(apu_rvalid), 1);
    check("bb_a_result", apu_result, 4);
    check("bb_gnt_c2", 32'(apu_gnt), 0);
    next_cycle();
    apu_req = 1'b0;
    @(negedge clk);
    check("bb_b_base0", 32'(lane_base_idx), 0);
    check("bb_b_mask0", 32'(lane_mask), 32'hF);
    check("bb_b_op", 32'(lane_op), 2);
    @(negedge clk);
    check("bb_b_base1", 32'(lane_base_idx), 4);
    check("bb_b_mask1", 32'(lane_mask), 32'h3);
    @(negedge clk);
    check("bb_b_rvalid", 32'(apu_rvalid), 1);
    check("bb_b_result", apu_result, 6);
    next_cycle();

    // Flush with active and pending ops.
    issue(6'd7, 8'd20);
    issue(6'd8, 8'd7);
    flush   = 1'b1;
    apu_req = 1'b1;
    @(negedge clk);
    check("fl_gnt", 32'(apu_gnt), 0);
    check("fl_busy_before", 32'(busy), 1);
    next_cycle();
    flush   = 1'b0;
    apu_req = 1'b0;
    exp_beats.delete();
    exp_res.delete();
    @(negedge clk);
    check("fl_busy", 32'(busy), 0);
    check("fl_valid", 32'(lane_valid), 0);
    check("fl_gnt_after", 32'(apu_gnt), 1);
    check("fl_rvalid", 32'(apu_rvalid), 0);
    repeat (4) begin
      @(negedge clk);
      check("fl_no_rvalid", 32'(apu_rvalid), 0);
    end
    next_cycle();

    // Reset mid-EXEC, then a fresh vl=4 op.
    issue(6'd9, 8'd12);
    reset = 1'b1;
    @(negedge clk);
    check("mr_gnt", 32'(apu_gnt), 0);
    next_cycle();
    reset = 1'b0;
    exp_beats.delete();
    exp_res.delete();
    @(negedge clk);
    check("mr_valid", 32'(lane_valid), 0);
    check("mr_rvalid", 32'(apu_rvalid), 0);
    check("mr_busy", 32'(busy), 0);
    check("mr_op", 32'(lane_op), 0);
    check("mr_base", 32'(lane_base_idx), 0);
    check("mr_mask", 32'(lane_mask), 0);
    check("mr_result", apu_result, 0);
    next_cycle();
    issue(6'd3, 8'd4);
    @(negedge clk);
    check("mr2_valid", 32'(lane_valid), 1);
    @(negedge clk);
    check("mr2_rvalid", 32'(apu_rvalid), 1);
    check("mr2_result", apu_result, 4);
    next_cycle();

    // Max vl: 64 beats, last base 252 mask 0111.
    issue(6'd42, 8'd255);
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      check("max_valid", 32'(lane_valid), 1);
      if (k == 63) begin
        check("max_last_base", 32'(lane_base_idx), 252);
        check("max_last_mask", 32'(lane_mask), 32'h7);
      end
    end
    @(negedge clk);
    check("max_rvalid", 32'(apu_rvalid), 1);
    check("max_result", apu_result, 255);
    next_cycle();

    // Randomized ops with random gaps and lane back-pressure.
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic [7:0] v;
          int sel;
          sel = int'($urandom_range(0, 15));
          if (sel == 0)      v = 8'd0;
          else if (sel == 1) v = 8'($urandom_range(200, 255));
          else               v = 8'($urandom_range(1, 40));
          repeat ($urandom_range(0, 3)) next_cycle();
          issue(6'($urandom_range(0, 63)), v);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          next_cycle();
          lane_stall = ($urandom_range(0, 3) == 0);
        end
        lane_stall = 1'b0;
      end
    join

    drain = 0;
    while ((busy || exp_beats.size() != 0 || exp_res.size() != 0) && drain < 3000) begin
      @(negedge clk);
      drain++;
    end
    check("drain_busy", 32'(busy), 0);
    check("drain_beats_left", 32'(exp_beats.size()), 0);
    check("drain_results_left", 32'(exp_res.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
